npc_mem_arbiter: RTL

Two-master, one-slave memory arbiter sitting directly downstream of the NPC's fetch unit (IFU) and load/store unit (LSU). It merges their requests onto a single memory port with a valid/ready request channel and a valid-only response channel. It allows one outstanding transaction and routes each response back to the master that issued it. It replaces the per-unit direct memory DPI paths and lets memory latency vary.

---
 rtl/npc_mem_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/npc_mem_arbiter.sv
// npc_mem_arbiter: merges IFU fetch and LSU load/store requests onto one memory port.
// Latency: accept at cycle 0, mem_req_valid at cycle 1, owner rsp_valid at the earliest at cycle 3.
// Backpressure: one transaction in flight; req_ready only in IDLE; REQ holds its payload until mem_req_ready.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   ifu_req_* / ifu_addr          fetch request (valid/ready)
//   ifu_rsp_*                     fetch response: one-cycle valid pulse; data/err held until the next fetch response
//   lsu_req_* / lsu_addr/wen/...  load/store request (valid/ready)
//   lsu_rsp_*                     load/store response; data is forced to 0 for stores
//   mem_req_* / mem_addr/...      registered request to the slave (valid/ready)
//   mem_rsp_*                     slave response (valid only), honoured only while waiting
//
// Build option: define NPC_ARB_RR_EN for round-robin tie-breaking; otherwise LSU always wins ties.

module npc_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [ADDR_W-1:0]     ifu_addr,
   output logic                  ifu_rsp_valid,
   output logic [DATA_W-1:0]     ifu_rsp_data,
   output logic                  ifu_rsp_err,

   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [ADDR_W-1:0]     lsu_addr,
   input  logic                  lsu_wen,
   input  logic [DATA_W-1:0]     lsu_wdata,
   input  logic [DATA_W/8-1:0]   lsu_wmask,
   output logic                  lsu_rsp_valid,
   output logic [DATA_W-1:0]     lsu_rsp_data,
   output logic                  lsu_rsp_err,

   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_wen,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wmask,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_W-1:0]     mem_rsp_data,
   input  logic                  mem_rsp_err
);

   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;   // 1 = LSU owns the transaction in flight
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;

   logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
   logic [DATA_W-1:0]   ifu_rsp_data_q, ifu_rsp_data_d;
   logic                ifu_rsp_err_q, ifu_rsp_err_d;
   logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
   logic [DATA_W-1:0]   lsu_rsp_data_q, lsu_rsp_data_d;
   logic                lsu_rsp_err_q, lsu_rsp_err_d;

   logic                lsu_prio;   // LSU wins when both masters request in the same cycle
   logic                lsu_wins;

`ifdef NPC_ARB_RR_EN
   // Remembers the last granted master; a tie goes to the other one.
   // Reset value 0 (last = IFU) makes the first tie go to the LSU.
   logic                last_lsu_q, last_lsu_d;
   assign lsu_prio = ~last_lsu_q;
`else
   assign lsu_prio = 1'b1;
`endif

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      addr_d          = addr_q;
      wen_d           = wen_q;
      wdata_d         = wdata_q;
      wmask_d         = wmask_q;
      ifu_rsp_valid_d = 1'b0;
      ifu_rsp_data_d  = ifu_rsp_data_q;
      ifu_rsp_err_d   = ifu_rsp_err_q;
      lsu_rsp_valid_d = 1'b0;
      lsu_rsp_data_d  = lsu_rsp_data_q;
      lsu_rsp_err_d   = lsu_rsp_err_q;
      ifu_req_ready   = 1'b0;
      lsu_req_ready   = 1'b0;
      mem_req_valid   = 1'b0;
      lsu_wins        = 1'b0;
`ifdef NPC_ARB_RR_EN
      last_lsu_d      = last_lsu_q;
`endif

      case (state_q)
         IDLE: begin
            lsu_wins = lsu_req_valid && (!ifu_req_valid || lsu_prio);
            if (lsu_wins) begin
               lsu_req_ready = 1'b1;
               owner_d       = 1'b1;
               addr_d        = lsu_addr;
               wen_d         = lsu_wen;
               wdata_d       = lsu_wdata;
               wmask_d       = lsu_wmask;
               state_d       = REQ;
`ifdef NPC_ARB_RR_EN
               last_lsu_d    = 1'b1;
`endif
            end else if (ifu_req_valid) begin
               // Fetches never write: clear the write-side payload.
               ifu_req_ready = 1'b1;
               owner_d       = 1'b0;
               addr_d        = ifu_addr;
               wen_d         = 1'b0;
               wdata_d       = '0;
               wmask_d       = '0;
               state_d       = REQ;
`ifdef NPC_ARB_RR_EN
               last_lsu_d    = 1'b0;
`endif
            end
         end

         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            // Only the owner's response registers move; the other master's stay untouched.
            if (mem_rsp_valid) begin
               state_d = IDLE;
               if (owner_q) begin
                  lsu_rsp_valid_d = 1'b1;
                  lsu_rsp_data_d  = wen_q ? '0 : mem_rsp_data;
                  lsu_rsp_err_d   = mem_rsp_err;
               end else begin
                  ifu_rsp_valid_d = 1'b1;
                  ifu_rsp_data_d  = mem_rsp_data;
                  ifu_rsp_err_d   = mem_rsp_err;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         owner_q         <= 1'b0;
         addr_q          <= '0;
         wen_q           <= 1'b0;
         wdata_q         <= '0;
         wmask_q         <= '0;
         ifu_rsp_valid_q <= 1'b0;
         ifu_rsp_data_q  <= '0;
         ifu_rsp_err_q   <= 1'b0;
         lsu_rsp_valid_q <= 1'b0;
         lsu_rsp_data_q  <= '0;
         lsu_rsp_err_q   <= 1'b0;
`ifdef NPC_ARB_RR_EN
         last_lsu_q      <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         addr_q          <= addr_d;
         wen_q           <= wen_d;
         wdata_q         <= wdata_d;
         wmask_q         <= wmask_d;
         ifu_rsp_valid_q <= ifu_rsp_valid_d;
         ifu_rsp_data_q  <= ifu_rsp_data_d;
         ifu_rsp_err_q   <= ifu_rsp_err_d;
         lsu_rsp_valid_q <= lsu_rsp_valid_d;
         lsu_rsp_data_q  <= lsu_rsp_data_d;
         lsu_rsp_err_q   <= lsu_rsp_err_d;
`ifdef NPC_ARB_RR_EN
         last_lsu_q      <= last_lsu_d;
`endif
      end
   end

   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;

   assign ifu_rsp_valid = ifu_rsp_valid_q;
   assign ifu_rsp_data  = ifu_rsp_data_q;
   assign ifu_rsp_err   = ifu_rsp_err_q;
   assign lsu_rsp_valid = lsu_rsp_valid_q;
   assign lsu_rsp_data  = lsu_rsp_data_q;
   assign lsu_rsp_err   = lsu_rsp_err_q;

endmodule
